// File: rtl/vga_pkg.sv
// Shared VGA pixel type, default palette and raster timing helpers.
package vga_pkg;
  typedef logic [11:0] rgb12_t;

  // Entry 0 is the rightmost element: black, white, red, green.
  localparam logic [3:0][11:0] DEF_PAL = {12'h0F0, 12'hF00, 12'hFFF, 12'h000};

  function automatic rgb12_t pal_default(input int unsigned idx);
    return (idx < 4) ? DEF_PAL[idx[1:0]] : 12'h000;
  endfunction

  function automatic int unsigned total_len(input int unsigned act, fp, sync, bp);
    return act + fp + sync + bp;
  endfunction

  function automatic logic in_sync(input int unsigned pos, act, fp, sync);
    return (pos >= act + fp) && (pos < act + fp + sync);
  endfunction
endpackage

// File: rtl/vga_timing.sv
// Raster h/v counters with sync, display-enable and frame-start decode.
// Outputs are combinational from the counter registers; no backpressure.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter int unsigned CNT_W    = 11,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_de,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_frame_start
);
  localparam int unsigned HT = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VT = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_de          = (32'(r_h) < H_ACTIVE) && (32'(r_v) < V_ACTIVE);
  assign o_hs          = in_sync(32'(r_h), H_ACTIVE, H_FP, H_SYNC) ? HS_POL : ~HS_POL;
  assign o_vs          = in_sync(32'(r_v), V_ACTIVE, V_FP, V_SYNC) ? VS_POL : ~VS_POL;
  assign o_frame_start = (r_h == '0) && (r_v == '0);
endmodule

// File: rtl/vga_fb_ctrl.sv
// Indexed-colour framebuffer scanned out to VGA: 3-cycle pixel pipeline with syncs aligned.
// Writes are never stalled except by reset or, optionally, outside vertical blanking.
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE       = 1280,
  parameter int unsigned H_FP           = 48,
  parameter int unsigned H_SYNC         = 112,
  parameter int unsigned H_BP           = 248,
  parameter int unsigned V_ACTIVE       = 1024,
  parameter int unsigned V_FP           = 1,
  parameter int unsigned V_SYNC         = 3,
  parameter int unsigned V_BP           = 38,
  parameter int unsigned CNT_W          = 11,
  parameter int unsigned BPP            = 2,
  parameter bit          HS_POL         = 1'b1,
  parameter bit          VS_POL         = 1'b1,
  parameter bit          WR_VBLANK_ONLY = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [CNT_W-1:0] wr_x_i,
  input  logic [CNT_W-1:0] wr_y_i,
  input  logic [BPP-1:0]   wr_color_i,
  input  logic             pal_we_i,
  input  logic [BPP-1:0]   pal_idx_i,
  input  logic [11:0]      pal_rgb_i,
  output logic             vga_hs_o,
  output logic             vga_vs_o,
  output logic [11:0]      rgb_o,
  output logic             frame_start_o,
  output logic             wr_drop_o
);
  localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned NPAL = 1 << BPP;

  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_de;
  logic             w_hs;
  logic             w_vs;
  logic             w_fs;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_de         (w_de),
    .o_hs         (w_hs),
    .o_vs         (w_vs),
    .o_frame_start(w_fs)
  );

  logic [BPP-1:0] r_fb [NPIX];
  rgb12_t         r_pal [NPAL];
  logic [BPP-1:0] r_fb_dat;
  rgb12_t         r_pal_dat;
  rgb12_t         r_rgb;
  logic [2:0]     r_de_d;
  logic [2:0]     r_hs_d;
  logic [2:0]     r_vs_d;
  logic [2:0]     r_fs_d;
  logic           r_drop;

  logic          w_wr_acc;
  logic          w_wr_in_range;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  assign wr_ready_o    = !rst_i && (!WR_VBLANK_ONLY || (32'(w_v) >= V_ACTIVE));
  assign w_wr_acc      = wr_valid_i && wr_ready_o;
  assign w_wr_in_range = (32'(wr_x_i) < H_ACTIVE) && (32'(wr_y_i) < V_ACTIVE);
  assign w_wr_addr     = AW'(32'(wr_y_i) * H_ACTIVE + 32'(wr_x_i));
  // Blanking reads are parked at address 0 so the index always stays in range.
  assign w_rd_addr     = w_de ? AW'(32'(w_v) * H_ACTIVE + 32'(w_h)) : '0;

  always_ff @(posedge clk_i) begin
    if (w_wr_acc && w_wr_in_range) begin
      r_fb[w_wr_addr] <= wr_color_i;
    end
  end

  always_ff @(posedge clk_i) begin
    r_fb_dat  <= r_fb[w_rd_addr];
    r_pal_dat <= r_pal[r_fb_dat];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NPAL; i++) begin
        r_pal[i] <= pal_default(i);
      end
    end else if (pal_we_i) begin
      r_pal[pal_idx_i] <= pal_rgb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_de_d <= '0;
      r_fs_d <= '0;
      r_hs_d <= {3{~HS_POL}};
      r_vs_d <= {3{~VS_POL}};
      r_rgb  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_de_d <= {r_de_d[1:0], w_de};
      r_fs_d <= {r_fs_d[1:0], w_fs};
      r_hs_d <= {r_hs_d[1:0], w_hs};
      r_vs_d <= {r_vs_d[1:0], w_vs};
      r_rgb  <= r_de_d[1] ? r_pal_dat : 12'h000;
      r_drop <= w_wr_acc && !w_wr_in_range;
    end
  end

  assign vga_hs_o      = r_hs_d[2];
  assign vga_vs_o      = r_vs_d[2];
  assign frame_start_o = r_fs_d[2];
  assign rgb_o         = r_rgb;
  assign wr_drop_o     = r_drop;
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl on a 14x7 raster (8x4 visible), active-low syncs.
module tb_vga_fb_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_valid, wr_ready, pal_we, hs, vs, fs, drop;
  logic [10:0] wr_x, wr_y;
  logic [1:0]  wr_color, pal_idx;
  logic [11:0] pal_rgb, rgb;

  logic        vb_valid, vb_ready, vb_hs, vb_vs, vb_fs, vb_drop;
  logic [10:0] vb_x, vb_y;
  logic [1:0]  vb_color;
  logic        vb_pal_we = 1'b0;
  logic [1:0]  vb_pal_idx = 2'd0;
  logic [11:0] vb_pal_rgb = 12'h000;
  logic [11:0] vb_rgb;

  int n_chk = 0;
  int n_bad = 0;

  vga_fb_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_W(11), .BPP(2), .HS_POL(1'b0), .VS_POL(1'b0), .WR_VBLANK_ONLY(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_color_i(wr_color),
    .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_rgb_i(pal_rgb),
    .vga_hs_o(hs), .vga_vs_o(vs), .rgb_o(rgb),
    .frame_start_o(fs), .wr_drop_o(drop)
  );

  vga_fb_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_W(11), .BPP(2), .HS_POL(1'b0), .VS_POL(1'b0), .WR_VBLANK_ONLY(1'b1)
  ) dut_vb (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(vb_valid), .wr_ready_o(vb_ready),
    .wr_x_i(vb_x), .wr_y_i(vb_y), .wr_color_i(vb_color),
    .pal_we_i(vb_pal_we), .pal_idx_i(vb_pal_idx), .pal_rgb_i(vb_pal_rgb),
    .vga_hs_o(vb_hs), .vga_vs_o(vb_vs), .rgb_o(vb_rgb),
    .frame_start_o(vb_fs), .wr_drop_o(vb_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-derived picture: seg 1 is the first run, seg 2 the run after the mid-frame reset.
  function automatic logic [11:0] exp_pix(input int seg, input int frm, input int x, input int y);
    if (x == 0 && y == 0) begin
      if (seg == 1) begin
        case (frm)
          1:       return 12'h0F0;
          2:       return 12'hFFF;
          default: return 12'h123;
        endcase
      end
      return 12'hFFF;
    end
    if (x == 3 && y == 2) return (seg == 1 && frm >= 2) ? 12'h123 : 12'hFFF;
    if (x == 7 && y == 3) return 12'hF00;
    return 12'h000;
  endfunction

  task automatic wr(input int x, input int y, input int col);
    wr_valid = 1'b1;
    wr_x     = 11'(x);
    wr_y     = 11'(y);
    wr_color = 2'(col);
  endtask

  // Outputs seen at iteration c belong to the pixel the counters held at iteration c-3.
  task automatic observe(input int seg, input int c, input bit rst_obs);
    int t, h, v, f;
    logic e_hs, e_vs, e_fs;
    logic [11:0] e_rgb;
    bit rgb_known;
    t = c - 3;
    e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 12'h000; rgb_known = 1'b1;
    if (!rst_obs && t >= 0) begin
      h = t % 14;
      v = (t / 14) % 7;
      f = t / 98;
      e_hs = !(h >= 10 && h < 12);
      e_vs = (v != 5);
      e_fs = (h == 0 && v == 0);
      if (h < 8 && v < 4) begin
        e_rgb = exp_pix(seg, f, h, v);
        rgb_known = !(seg == 1 && f == 0);
      end
    end
    chk($sformatf("hs s%0d c%0d", seg, c), hs, e_hs);
    chk($sformatf("vs s%0d c%0d", seg, c), vs, e_vs);
    chk($sformatf("fs s%0d c%0d", seg, c), fs, e_fs);
    chk($sformatf("vb_hs s%0d c%0d", seg, c), vb_hs, e_hs);
    chk($sformatf("vb_vs s%0d c%0d", seg, c), vb_vs, e_vs);
    chk($sformatf("vb_fs s%0d c%0d", seg, c), vb_fs, e_fs);
    if (rgb_known) chk($sformatf("rgb s%0d c%0d", seg, c), rgb, e_rgb);
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    pal_we = 1'b0; pal_idx = '0; pal_rgb = '0;
    vb_valid = 1'b0; vb_x = 11'd1; vb_y = 11'd1; vb_color = 2'd2;
    repeat (4) @(negedge clk);
    chk("rst hs", hs, 1'b1);
    chk("rst vs", vs, 1'b1);
    chk("rst rgb", rgb, 12'h000);
    chk("rst fs", fs, 1'b0);
    chk("rst drop", drop, 1'b0);
    chk("rst ready", wr_ready, 1'b0);
    chk("rst vb_ready", vb_ready, 1'b0);

    // First run: clear memory, paint three pixels, probe drops, read-first, palette, reset.
    for (int c = 0; c < 347; c++) begin
      rst      = (c >= 344);
      wr_valid = 1'b0;
      pal_we   = 1'b0;
      if (c < 32) wr(c % 8, c / 8, 0);
      else begin
        case (c)
          32:            wr(3, 2, 1);
          33:            wr(0, 0, 3);
          34:            wr(7, 3, 2);
          36:            wr(8, 0, 1);
          38:            wr(0, 4, 1);
          98:            wr(0, 0, 1);
          344, 345, 346: wr(5, 1, 1);
          default:       ;
        endcase
      end
      if (c == 197) begin
        pal_we  = 1'b1;
        pal_idx = 2'd1;
        pal_rgb = 12'h123;
      end
      vb_valid = (c <= 56);
      #1;
      observe(1, c, c >= 345);
      chk($sformatf("ready s1 c%0d", c), wr_ready, c < 344);
      chk($sformatf("vb_ready s1 c%0d", c), vb_ready, (c < 344) && (((c / 14) % 7) >= 4));
      chk($sformatf("drop s1 c%0d", c), drop, (c == 37 || c == 39));
      chk($sformatf("vb_drop s1 c%0d", c), vb_drop, 1'b0);
      if (c == 116) chk("vb_pix_1_1", vb_rgb, 12'hF00);
      @(negedge clk);
    end

    // After release: timing restarts at (0,0), palette back to defaults, memory kept.
    for (int c = 0; c < 200; c++) begin
      rst      = 1'b0;
      wr_valid = 1'b0;
      pal_we   = 1'b0;
      vb_valid = 1'b0;
      #1;
      observe(2, c, 1'b0);
      chk($sformatf("ready s2 c%0d", c), wr_ready, 1'b1);
      chk($sformatf("vb_ready s2 c%0d", c), vb_ready, ((c / 14) % 7) >= 4);
      chk($sformatf("drop s2 c%0d", c), drop, 1'b0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_fb_ctrl.md
VGA_FB_CTRL -- requirements
Module: vga_fb_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 1280 visible pixels/line; H_FP 48 h front porch; H_SYNC 112 h sync width; H_BP 248 h back porch.
REQ-002 SHALL have parameters: V_ACTIVE 1024 visible lines; V_FP 1; V_SYNC 3; V_BP 38; CNT_W 11 counter/coordinate width.
REQ-003 SHALL have parameters: BPP 2 bits per pixel index; HS_POL 1 and VS_POL 1 (active sync level); WR_VBLANK_ONLY 0 (1 = writes accepted only in vertical blanking).
REQ-004 SHALL have ports (name, direction, width, meaning): clk_i in 1 sole clock; rst_i in 1 synchronous active-high reset.
REQ-005 SHALL have ports: wr_valid_i in 1 write request; wr_ready_o out 1 write accept; wr_x_i in CNT_W column; wr_y_i in CNT_W row; wr_color_i in BPP palette index.
REQ-006 SHALL have ports: pal_we_i in 1 palette write; pal_idx_i in BPP entry; pal_rgb_i in 12 {R,G,B} 4 bits each.
REQ-007 SHALL have ports: vga_hs_o out 1; vga_vs_o out 1; rgb_o out 12; frame_start_o out 1 one-cycle pulse; wr_drop_o out 1 one-cycle pulse on a discarded write.

Function
REQ-008 h counter SHALL count 0..HT-1 (HT = H_ACTIVE+H_FP+H_SYNC+H_BP), wrapping to 0; v counter SHALL increment on h wrap and count 0..VT-1, wrapping to 0.
REQ-009 Line order SHALL be active [0,H_ACTIVE), front porch, sync, back porch; sync asserted (=HS_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vertical identical with V_* and VS_POL.
REQ-010 Framebuffer SHALL hold H_ACTIVE*V_ACTIVE entries of BPP bits, address = y*H_ACTIVE + x (row-major), width ceil(log2(H_ACTIVE*V_ACTIVE)).
REQ-011 Pixel pipeline SHALL be 3 cycles: counters -> framebuffer read -> palette lookup -> output register; vga_hs_o, vga_vs_o and display-enable SHALL be delayed by the same 3 cycles so sync and pixel stay aligned.
REQ-012 rgb_o SHALL be 12'h000 whenever the delayed display-enable is low.
REQ-013 frame_start_o SHALL pulse for exactly one cycle, aligned with rgb_o of pixel (0,0).
REQ-014 A write SHALL be accepted on the cycle wr_valid_i & wr_ready_o; one write per cycle max; accepted data SHALL be readable by the display from the next cycle.
REQ-015 WR_VBLANK_ONLY=0: wr_ready_o SHALL be 1 every cycle outside reset; WR_VBLANK_ONLY=1: wr_ready_o SHALL be 1 only while v counter >= V_ACTIVE.
REQ-016 Accepted write with wr_x_i >= H_ACTIVE or wr_y_i >= V_ACTIVE SHALL not modify memory and SHALL pulse wr_drop_o the following cycle.
REQ-017 Palette SHALL hold 2**BPP entries; pal_we_i SHALL write pal_rgb_i to pal_idx_i at the clock edge; a lookup of the same index in the same cycle SHALL return the old value.
REQ-018 Framebuffer write and display read of the same address in the same cycle SHALL return the old value (read-first).

Reset
REQ-019 While rst_i=1: counters 0, vga_hs_o=!HS_POL, vga_vs_o=!VS_POL, rgb_o=0, frame_start_o=0, wr_drop_o=0, wr_ready_o=0, pipeline valid bits cleared.
REQ-020 Palette SHALL reset to idx0=12'h000, idx1=12'hFFF, idx2=12'hF00, idx3=12'h0F0, others 12'h000; framebuffer contents SHALL not be reset.
REQ-021 Reset asserted mid-frame SHALL abort the frame; the first cycle after release SHALL be h=0, v=0; a write presented during reset SHALL be ignored.

Structure
REQ-022 Package vga_pkg SHALL hold rgb12_t, the default palette constant and the HT/VT/sync-window helper functions.
REQ-023 Counter and sync generation SHALL be the sub-module vga_timing (outputs h, v, de, hs, vs, frame_start); memory, palette and pipeline stay in vga_fb_ctrl.

Verification (bench params H_ACTIVE=8 H_FP=2 H_SYNC=2 H_BP=2 V_ACTIVE=4 V_FP=1 V_SYNC=1 V_BP=1 BPP=2)
REQ-024 Free run after reset -> vga_hs_o low 2 cycles per 14-cycle line at h 10..11 (+3 latency); vga_vs_o low for line 5; frame_start_o every 98 cycles.
REQ-025 Write (x=3,y=2,color=1) -> rgb_o=12'hFFF exactly at pixel (3,2) of next frame, 12'h000 elsewhere (memory zero-initialised in sim).
REQ-026 Write (x=8,y=0) and (x=0,y=4) -> two wr_drop_o pulses, no memory change.
REQ-027 WR_VBLANK_ONLY=1, wr_valid_i held from v=0 -> wr_ready_o=0 until v=4, write accepted first cycle of v=4.
REQ-028 pal_we_i idx1=12'h123 during active video -> following idx1 pixels show 12'h123; rst_i pulsed mid-frame -> outputs at reset values, palette idx1 back to 12'hFFF, timing restarts at (0,0).
